clk_wiz_reset_seq: RTL

//  Sequencer for clk_wiz_alu. Runs on the free-running board clock that also drives clk_in1.

---
 rtl/clk_wiz_reset_seq_if.sv | 42 ++++
 rtl/clk_wiz_reset_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_wiz_reset_seq_if.sv
// ---------------------------------------------------------------------------
// clk_wiz_reset_seq_if
//   Signal bundle between the reset sequencer and the clocking wizard /
//   downstream clock domains.
//
//   Signal semantics (there is no valid/ready pair on this link):
//     locked     : level from the wizard. It is asynchronous to clk, so the
//                  sequencer synchronises it before use.
//     relock_req : single-cycle pulse sampled on clk. A high level for one
//                  clk cycle starts a fresh lock sequence.
//     pll_reset, core_rst, ready, lock_fail, try_cnt :
//                  registered levels. They change only on a clk edge, or
//                  asynchronously when the sequencer is reset.
//     dbg_state  : current sequencer state, for debug and checkers.
//
//   Modports
//     master : the sequencer. It drives the reset/status outputs.
//     slave  : the wizard / domain side. It drives locked and relock_req.
// ---------------------------------------------------------------------------
interface clk_wiz_reset_seq_if #(
  parameter int N_DOM = 3,
  parameter int TRY_W = 2
);
  logic             locked;
  logic             relock_req;
  logic             pll_reset;
  logic [N_DOM-1:0] core_rst;
  logic             ready;
  logic             lock_fail;
  logic [TRY_W-1:0] try_cnt;
  logic [2:0]       dbg_state;

  modport master (
    input  locked, relock_req,
    output pll_reset, core_rst, ready, lock_fail, try_cnt, dbg_state
  );

  modport slave (
    output locked, relock_req,
    input  pll_reset, core_rst, ready, lock_fail, try_cnt, dbg_state
  );
endinterface

// File: rtl/clk_wiz_reset_seq.sv
// ---------------------------------------------------------------------------
// clk_wiz_reset_seq
//   Reset sequencer for clk_wiz_alu. It runs on the free-running board clock,
//   which is the same net as the wizard's clk_in1.
//   Sequence of operation:
//     1. Pulse the wizard reset.
//     2. Wait for lock, then require lock to stay stable.
//     3. Release the per-domain core resets one at a time, bit 0 first.
//   A failed attempt is retried. After MAX_TRY lock timeouts the sequencer
//   stops in a fatal state until it is reset or receives relock_req.
//
// Ports
//   clk   : board clock
//   reset : asynchronous, active-high block reset
//   bus   : clk_wiz_reset_seq_if.master
//             in  : locked, relock_req
//             out : pll_reset, core_rst[N_DOM-1:0], ready, lock_fail,
//                   try_cnt, dbg_state
// ---------------------------------------------------------------------------
module clk_wiz_reset_seq #(
  parameter int N_DOM         = 3,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int STAGGER       = 8,
  parameter int MAX_TRY       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  clk_wiz_reset_seq_if.master  bus
);

  localparam int TRY_W   = $clog2(MAX_TRY + 1);
  localparam int MAX_A   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int MAX_B   = (RST_CYCLES > N_DOM * STAGGER) ? RST_CYCLES : N_DOM * STAGGER;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'((N_DOM - 1) * STAGGER);
  localparam logic [TRY_W-1:0] TRY_LIMIT   = TRY_W'(MAX_TRY);

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_REL    = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TRY_W-1:0] try_q, try_n, try_sat;
  logic [1:0]       sync_q;
  logic             locked_s;

  logic             pll_reset_q, pll_reset_n;
  logic [N_DOM-1:0] core_rst_q, core_rst_n;
  logic             ready_q, ready_n;
  logic             lock_fail_q, lock_fail_n;
  logic [N_DOM-1:0] rel_mask;

  assign locked_s = sync_q[1];
  assign try_sat  = (try_q == TRY_LIMIT) ? try_q : try_q + TRY_W'(1);

  // State register. The synchroniser flops and all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_PLLRST;
      cnt         <= '0;
      try_q       <= '0;
      sync_q      <= '0;
      pll_reset_q <= 1'b1;
      core_rst_q  <= '1;
      ready_q     <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      try_q       <= try_n;
      sync_q      <= {sync_q[0], bus.locked};
      pll_reset_q <= pll_reset_n;
      core_rst_q  <= core_rst_n;
      ready_q     <= ready_n;
      lock_fail_q <= lock_fail_n;
    end
  end

  // Next-state logic.
  // A "restart" sends the sequencer back to S_PLLRST with cnt and try_cnt cleared.
  // relock_req is tested first in every state, so it wins over a timeout or a
  // release decided on the same edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    try_n   = try_q;
    unique case (state)
      S_PLLRST: begin
        if (bus.relock_req) begin
          cnt_n = '0;                       // restart the pulse; try_cnt is kept
        end else if (cnt == RST_LAST) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end
      end
      S_WAIT: begin
        if (bus.relock_req) begin
          state_n = S_PLLRST;
          cnt_n   = '0;
          try_n   = '0;
        end else if (locked_s) begin
          state_n = S_STABLE;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          try_n   = try_sat;
          cnt_n   = '0;
          state_n = (try_sat == TRY_LIMIT) ? S_FAIL : S_PLLRST;
        end
      end
      S_STABLE: begin
        if (bus.relock_req) begin
          state_n = S_PLLRST;
          cnt_n   = '0;
          try_n   = '0;
        end else if (!locked_s) begin
          state_n = S_WAIT;                 // glitch: lock timeout restarts, try_cnt kept
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = S_REL;
          cnt_n   = '0;
        end
      end
      S_REL: begin
        if (bus.relock_req || !locked_s) begin
          state_n = S_PLLRST;
          cnt_n   = '0;
          try_n   = '0;
        end else if (cnt == REL_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end
      end
      S_RUN: begin
        cnt_n = '0;                         // hold cnt so it cannot wrap while running
        if (bus.relock_req || !locked_s) begin
          state_n = S_PLLRST;
          try_n   = '0;
        end
      end
      S_FAIL: begin
        cnt_n = '0;
        if (bus.relock_req) begin
          state_n = S_PLLRST;
          try_n   = '0;
        end
      end
      default: begin
        state_n = S_PLLRST;
        cnt_n   = '0;
        try_n   = '0;
      end
    endcase
  end

  // Output logic.
  // Outputs are computed from the next state, so the registered outputs
  // line up with the state they describe.
  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < N_DOM; i++) begin
      rel_mask[i] = (cnt == CNT_W'(i * STAGGER));
    end

    pll_reset_n = (state_n == S_PLLRST) || (state_n == S_FAIL);
    ready_n     = (state_n == S_RUN);
    lock_fail_n = (state_n == S_FAIL);
    core_rst_n  = '1;
    if (state_n == S_RUN) begin
      core_rst_n = '0;
    end else if (state_n == S_REL && state == S_REL) begin
      // Bits released earlier stay released. On entry to S_REL all bits
      // are still held.
      core_rst_n = core_rst_q & ~rel_mask;
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.core_rst  = core_rst_q;
  assign bus.ready     = ready_q;
  assign bus.lock_fail = lock_fail_q;
  assign bus.try_cnt   = try_q;
  assign bus.dbg_state = state;

endmodule
